// File: rtl/ghost_pkg.sv
// Shared constants for the ghost target generator.
// Mode and direction encodings, jail tiles, look-ahead distance.
package ghost_pkg;

  typedef enum logic [1:0] {
    MODE_EXIT    = 2'b00,
    MODE_SCATTER = 2'b01,
    MODE_ATTACK  = 2'b10,
    MODE_HOME    = 2'b11
  } mode_e;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam int JAIL_EXIT_X = 10;
  localparam int JAIL_EXIT_Y = 9;
  localparam int JAIL_IN_X   = 10;
  localparam int JAIL_IN_Y   = 12;

  localparam int LOOKAHEAD = 4;

endpackage

// File: rtl/ghost_target_gen_if.sv
// Game-state inputs and per-ghost target outputs.
// master = game logic side, slave = target generator.
interface ghost_target_gen_if #(
  parameter int NUM_GHOSTS = 4,
  parameter int COORD_W    = 5
);
  logic [1:0]                    ghost_mode;
  logic                          level;
  logic [COORD_W-1:0]            pacman_x;
  logic [COORD_W-1:0]            pacman_y;
  logic [3:0]                    pacman_dir;
  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x;
  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y;
  logic [NUM_GHOSTS-1:0]         ghost_eaten;
  logic [NUM_GHOSTS*COORD_W-1:0] target_x;
  logic [NUM_GHOSTS*COORD_W-1:0] target_y;
  logic [NUM_GHOSTS-1:0]         returning;
  logic [NUM_GHOSTS*2-1:0]       wp_idx;

  modport master (
    output ghost_mode, level, pacman_x, pacman_y,
    output pacman_dir, ghost_x, ghost_y, ghost_eaten,
    input  target_x, target_y, returning, wp_idx
  );

  modport slave (
    input  ghost_mode, level, pacman_x, pacman_y,
    input  pacman_dir, ghost_x, ghost_y, ghost_eaten,
    output target_x, target_y, returning, wp_idx
  );
endinterface

// File: rtl/ghost_corner_rom.sv
// Scatter waypoint table, indexed by level, ghost slot
// and waypoint index. Purely combinational.
module ghost_corner_rom #(
  parameter int COORD_W = 5
) (
  input  logic               i_level,
  input  logic [1:0]         i_slot,
  input  logic [1:0]         i_idx,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y
);
  int w_x;
  int w_y;

  always_comb begin
    w_x = 0;
    w_y = 0;
    case ({i_level, i_slot, i_idx})
      5'b0_00_00: begin w_x = 14; w_y = 3;  end
      5'b0_00_01: begin w_x = 14; w_y = 1;  end
      5'b0_00_10: begin w_x = 21; w_y = 1;  end
      5'b0_00_11: begin w_x = 21; w_y = 3;  end
      5'b0_01_00: begin w_x = 14; w_y = 17; end
      5'b0_01_01: begin w_x = 14; w_y = 21; end
      5'b0_01_10: begin w_x = 17; w_y = 21; end
      5'b0_01_11: begin w_x = 17; w_y = 17; end
      5'b0_10_00: begin w_x = 4;  w_y = 3;  end
      5'b0_10_01: begin w_x = 4;  w_y = 1;  end
      5'b0_10_10: begin w_x = 1;  w_y = 1;  end
      5'b0_10_11: begin w_x = 1;  w_y = 3;  end
      5'b0_11_00: begin w_x = 4;  w_y = 17; end
      5'b0_11_01: begin w_x = 4;  w_y = 21; end
      5'b0_11_10: begin w_x = 1;  w_y = 21; end
      5'b0_11_11: begin w_x = 1;  w_y = 17; end
      5'b1_00_00: begin w_x = 15; w_y = 4;  end
      5'b1_00_01: begin w_x = 13; w_y = 3;  end
      5'b1_00_10: begin w_x = 17; w_y = 1;  end
      5'b1_00_11: begin w_x = 17; w_y = 5;  end
      5'b1_01_00: begin w_x = 12; w_y = 17; end
      5'b1_01_01: begin w_x = 12; w_y = 21; end
      5'b1_01_10: begin w_x = 14; w_y = 21; end
      5'b1_01_11: begin w_x = 14; w_y = 17; end
      5'b1_10_00: begin w_x = 3;  w_y = 4;  end
      5'b1_10_01: begin w_x = 5;  w_y = 3;  end
      5'b1_10_10: begin w_x = 1;  w_y = 1;  end
      5'b1_10_11: begin w_x = 1;  w_y = 5;  end
      5'b1_11_00: begin w_x = 7;  w_y = 19; end
      5'b1_11_01: begin w_x = 4;  w_y = 19; end
      5'b1_11_10: begin w_x = 4;  w_y = 21; end
      5'b1_11_11: begin w_x = 7;  w_y = 21; end
      default:    begin w_x = 0;  w_y = 0;  end
    endcase
  end

  assign o_x = COORD_W'(w_x);
  assign o_y = COORD_W'(w_y);

endmodule

// File: rtl/ghost_target_gen.sv
// Per-ghost registered target tiles for the ghost AI.
// Optional attack look-ahead for slot 2: GHOST_LOOKAHEAD_EN.
module ghost_target_gen
  import ghost_pkg::*;
#(
  parameter int NUM_GHOSTS = 4,
  parameter int COORD_W    = 5,
  parameter int MAP_MAX    = 21
) (
  input logic         clk_50mhz,
  input logic         reset_n,
  ghost_target_gen_if.slave ifc
);
  localparam logic [COORD_W-1:0] EX_X = COORD_W'(JAIL_EXIT_X);
  localparam logic [COORD_W-1:0] EX_Y = COORD_W'(JAIL_EXIT_Y);
  localparam logic [COORD_W-1:0] IN_X = COORD_W'(JAIL_IN_X);
  localparam logic [COORD_W-1:0] IN_Y = COORD_W'(JAIL_IN_Y);

  logic [1:0] r_prev_mode;
  logic       w_scat_entry;

  assign w_scat_entry = (ifc.ghost_mode == MODE_SCATTER) &&
                        (r_prev_mode != MODE_SCATTER);

  always_ff @(posedge clk_50mhz) begin
    if (!reset_n) r_prev_mode <= MODE_EXIT;
    else          r_prev_mode <= ifc.ghost_mode;
  end

`ifdef GHOST_LOOKAHEAD_EN
  function automatic logic [COORD_W-1:0] f_inc(
    input logic [COORD_W-1:0] v
  );
    logic [COORD_W:0] s;
    s = {1'b0, v} + (COORD_W+1)'(LOOKAHEAD);
    if (s > (COORD_W+1)'(MAP_MAX)) return COORD_W'(MAP_MAX);
    return s[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] f_dec(
    input logic [COORD_W-1:0] v
  );
    logic [COORD_W:0] s;
    s = {1'b0, v};
    if (s < (COORD_W+1)'(LOOKAHEAD)) return '0;
    s = s - (COORD_W+1)'(LOOKAHEAD);
    return s[COORD_W-1:0];
  endfunction
`endif

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
    localparam logic [1:0] SLOT = 2'(g % 4);

    logic [COORD_W-1:0] w_gx, w_gy;
    logic [COORD_W-1:0] w_rx, w_ry;
    logic [COORD_W-1:0] w_ax, w_ay;
    logic [COORD_W-1:0] r_tx, r_ty;
    logic [1:0]         r_wp, w_ridx;
    logic               r_ret, w_ret_nxt;
    logic               w_at_wp, w_at_home;

    assign w_gx = ifc.ghost_x[g*COORD_W +: COORD_W];
    assign w_gy = ifc.ghost_y[g*COORD_W +: COORD_W];

    // Entering scatter restarts the tour at waypoint 0 immediately.
    assign w_ridx = w_scat_entry ? 2'd0 : r_wp;

    ghost_corner_rom #(.COORD_W(COORD_W)) u_rom (
      .i_level (ifc.level),
      .i_slot  (SLOT),
      .i_idx   (w_ridx),
      .o_x     (w_rx),
      .o_y     (w_ry)
    );

    assign w_at_wp   = (w_gx == w_rx) && (w_gy == w_ry);
    assign w_at_home = (w_gx == IN_X) && (w_gy == IN_Y);
    assign w_ret_nxt = ifc.ghost_eaten[g] | (r_ret & ~w_at_home);

`ifdef GHOST_LOOKAHEAD_EN
    if (SLOT == 2'd2) begin : g_look
      always_comb begin
        w_ax = ifc.pacman_x;
        w_ay = ifc.pacman_y;
        case (ifc.pacman_dir)
          DIR_UP:    w_ay = f_dec(ifc.pacman_y);
          DIR_DOWN:  w_ay = f_inc(ifc.pacman_y);
          DIR_LEFT:  w_ax = f_dec(ifc.pacman_x);
          DIR_RIGHT: w_ax = f_inc(ifc.pacman_x);
          default: ;
        endcase
      end
    end else begin : g_plain
      assign w_ax = ifc.pacman_x;
      assign w_ay = ifc.pacman_y;
    end
`else
    assign w_ax = ifc.pacman_x;
    assign w_ay = ifc.pacman_y;
`endif

    always_ff @(posedge clk_50mhz) begin
      if (!reset_n) begin
        r_tx  <= EX_X;
        r_ty  <= EX_Y;
        r_ret <= 1'b0;
        r_wp  <= 2'd0;
      end else begin
        r_ret <= w_ret_nxt;
        if (w_scat_entry)
          r_wp <= 2'd0;
        else if (ifc.ghost_mode == MODE_SCATTER && !r_ret && w_at_wp)
          r_wp <= r_wp + 2'd1;
        if (w_ret_nxt) begin
          r_tx <= IN_X;
          r_ty <= IN_Y;
        end else begin
          case (ifc.ghost_mode)
            MODE_EXIT:    begin r_tx <= EX_X; r_ty <= EX_Y; end
            MODE_SCATTER: begin r_tx <= w_rx; r_ty <= w_ry; end
            MODE_ATTACK:  begin r_tx <= w_ax; r_ty <= w_ay; end
            default:      begin r_tx <= IN_X; r_ty <= IN_Y; end
          endcase
        end
      end
    end

    assign ifc.target_x[g*COORD_W +: COORD_W] = r_tx;
    assign ifc.target_y[g*COORD_W +: COORD_W] = r_ty;
    assign ifc.returning[g]                   = r_ret;
    assign ifc.wp_idx[g*2 +: 2]               = r_wp;
  end

endmodule
